// File: rtl/ddr4_cmd_encoder.sv
// DDR4 command/address initiator: turns a valid/ready request stream into CA-bus pin states,
// tracking per-bank open state, minimum command spacing and CA parity.
module ddr4_cmd_encoder #(
    parameter int unsigned AWIDTH = 17,
    parameter int unsigned BWIDTH = 2,
    parameter int unsigned GWIDTH = 2,
    parameter int unsigned T_INIT = 16,
    parameter int unsigned T_RCD  = 4,
    parameter int unsigned T_CCD  = 4,
    parameter int unsigned T_RP   = 4,
    parameter int unsigned T_RFC  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [2:0]        cmd_op,
    input  logic [GWIDTH-1:0] cmd_bg,
    input  logic [BWIDTH-1:0] cmd_ba,
    input  logic [AWIDTH-1:0] cmd_row,
    input  logic [9:0]        cmd_col,
    input  logic              cmd_ap,
    input  logic              cmd_bc_n,
    output logic              ddr4_cke,
    output logic              ddr4_cs_n,
    output logic              ddr4_act_n,
    output logic [AWIDTH-1:0] ddr4_addr,
    output logic [GWIDTH-1:0] ddr4_bg,
    output logic [BWIDTH-1:0] ddr4_ba,
    output logic              ddr4_par,
    output logic              cmd_err
);
    localparam int unsigned IWIDTH = GWIDTH + BWIDTH;
    localparam int unsigned NBANK  = 1 << IWIDTH;
    localparam int unsigned TMAX0  = (T_INIT > T_RCD) ? T_INIT : T_RCD;
    localparam int unsigned TMAX1  = (T_CCD > T_RP) ? T_CCD : T_RP;
    localparam int unsigned TMAX2  = (TMAX0 > TMAX1) ? TMAX0 : TMAX1;
    localparam int unsigned TMAX   = (TMAX2 > T_RFC) ? TMAX2 : T_RFC;
    localparam int unsigned CWIDTH = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        OpDes  = 3'd0,
        OpAct  = 3'd1,
        OpRd   = 3'd2,
        OpWr   = 3'd3,
        OpPre  = 3'd4,
        OpPrea = 3'd5,
        OpRef  = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait
    } state_e;

    state_e              state;
    logic [CWIDTH-1:0]   cnt;
    logic [NBANK-1:0]    bank_open;

    op_e                 op;
    logic [IWIDTH-1:0]   bidx;
    logic                sel_open;
    logic                accept;
    logic                illegal;
    logic                issue;
    logic [CWIDTH-1:0]   nxt_wait;
    logic [NBANK-1:0]    nxt_banks;
    logic [AWIDTH-1:0]   enc_addr;
    logic                enc_act_n;
    logic                nxt_cs_n;
    logic                nxt_act_n;
    logic [AWIDTH-1:0]   nxt_addr;
    logic [GWIDTH-1:0]   nxt_bg;
    logic [BWIDTH-1:0]   nxt_ba;
    logic                nxt_par;

    assign op       = op_e'(cmd_op);
    assign bidx     = {cmd_bg, cmd_ba};
    assign sel_open = bank_open[bidx];
    assign accept   = cmd_vld & cmd_rdy;

    // Decode the offered request into legality, pin encoding, spacing and bank effect.
    always_comb begin
        illegal   = 1'b0;
        nxt_wait  = '0;
        nxt_banks = bank_open;
        enc_addr  = '0;
        enc_act_n = 1'b1;
        unique case (op)
            OpDes: ;
            OpAct: begin
                illegal          = sel_open;
                enc_act_n        = 1'b0;
                enc_addr         = cmd_row;
                nxt_wait         = CWIDTH'(T_RCD - 1);
                nxt_banks[bidx]  = 1'b1;
            end
            OpRd, OpWr: begin
                illegal          = ~sel_open;
                enc_addr[16:14]  = (op == OpRd) ? 3'b101 : 3'b100;
                enc_addr[12]     = cmd_bc_n;
                enc_addr[10]     = cmd_ap;
                enc_addr[9:0]    = cmd_col;
                nxt_wait         = CWIDTH'(T_CCD - 1);
                if (cmd_ap) begin
                    nxt_banks[bidx] = 1'b0;
                end
            end
            OpPre: begin
                enc_addr[16:14]  = 3'b010;
                nxt_wait         = CWIDTH'(T_RP - 1);
                nxt_banks[bidx]  = 1'b0;
            end
            OpPrea: begin
                enc_addr[16:14]  = 3'b010;
                enc_addr[10]     = 1'b1;
                nxt_wait         = CWIDTH'(T_RP - 1);
                nxt_banks        = '0;
            end
            OpRef: begin
                illegal          = |bank_open;
                enc_addr[16:14]  = 3'b001;
                nxt_wait         = CWIDTH'(T_RFC - 1);
            end
            OpRsvd: illegal = 1'b1;
        endcase
    end

    assign issue = accept & ~illegal & (op != OpDes);

    // Pins show DES unless a legal command is being issued this edge.
    always_comb begin
        nxt_cs_n  = 1'b1;
        nxt_act_n = 1'b1;
        nxt_addr  = '1;
        nxt_bg    = '0;
        nxt_ba    = '0;
        if (issue) begin
            nxt_cs_n  = 1'b0;
            nxt_act_n = enc_act_n;
            nxt_addr  = enc_addr;
            nxt_bg    = cmd_bg;
            nxt_ba    = cmd_ba;
        end
        nxt_par = ^{nxt_act_n, nxt_bg, nxt_ba, nxt_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StInit;
            cnt        <= '0;
            bank_open  <= '0;
            ddr4_cke   <= 1'b0;
            ddr4_cs_n  <= 1'b1;
            ddr4_act_n <= 1'b1;
            ddr4_addr  <= '0;
            ddr4_bg    <= '0;
            ddr4_ba    <= '0;
            ddr4_par   <= 1'b0;
            cmd_rdy    <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            ddr4_cs_n  <= nxt_cs_n;
            ddr4_act_n <= nxt_act_n;
            ddr4_addr  <= nxt_addr;
            ddr4_bg    <= nxt_bg;
            ddr4_ba    <= nxt_ba;
            ddr4_par   <= nxt_par;
            cmd_err    <= accept & illegal;
            if (issue) begin
                bank_open <= nxt_banks;
            end
            case (state)
                StInit: begin
                    if (cnt == CWIDTH'(T_INIT - 1)) begin
                        state    <= StIdle;
                        cnt      <= '0;
                        ddr4_cke <= 1'b1;
                        cmd_rdy  <= 1'b1;
                    end else begin
                        cnt <= cnt + CWIDTH'(1);
                    end
                end
                StIdle: begin
                    if (issue) begin
                        state   <= StWait;
                        cnt     <= nxt_wait;
                        cmd_rdy <= 1'b0;
                    end
                end
                StWait: begin
                    // Counter reaches zero on the same edge that re-opens the request port.
                    if (cnt <= CWIDTH'(1)) begin
                        state   <= StIdle;
                        cnt     <= '0;
                        cmd_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - CWIDTH'(1);
                    end
                end
                default: begin
                    state   <= StInit;
                    cnt     <= '0;
                    cmd_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_encoder.sv
// Directed bench for ddr4_cmd_encoder: cycle-level scoreboard model plus literal pin checks.
module tb_ddr4_cmd_encoder;
    localparam int T_INIT = 16;
    localparam int T_RCD  = 4;
    localparam int T_CCD  = 4;
    localparam int T_RP   = 4;
    localparam int T_RFC  = 32;

    localparam logic [2:0] OP_DES  = 3'd0;
    localparam logic [2:0] OP_ACT  = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_WR   = 3'd3;
    localparam logic [2:0] OP_PRE  = 3'd4;
    localparam logic [2:0] OP_PREA = 3'd5;
    localparam logic [2:0] OP_REF  = 3'd6;
    localparam logic [2:0] OP_RSV  = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_bg = '0;
    logic [1:0]  cmd_ba = '0;
    logic [16:0] cmd_row = '0;
    logic [9:0]  cmd_col = '0;
    logic        cmd_ap = 1'b0;
    logic        cmd_bc_n = 1'b1;
    logic        ddr4_cke, ddr4_cs_n, ddr4_act_n, ddr4_par, cmd_err;
    logic [16:0] ddr4_addr;
    logic [1:0]  ddr4_bg, ddr4_ba;

    always #5 clk = ~clk;

    ddr4_cmd_encoder #(
        .AWIDTH(17), .BWIDTH(2), .GWIDTH(2), .T_INIT(T_INIT),
        .T_RCD(T_RCD), .T_CCD(T_CCD), .T_RP(T_RP), .T_RFC(T_RFC)
    ) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_ap(cmd_ap), .cmd_bc_n(cmd_bc_n), .ddr4_cke(ddr4_cke), .ddr4_cs_n(ddr4_cs_n),
        .ddr4_act_n(ddr4_act_n), .ddr4_addr(ddr4_addr), .ddr4_bg(ddr4_bg),
        .ddr4_ba(ddr4_ba), .ddr4_par(ddr4_par), .cmd_err(cmd_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ca_addr(input logic [2:0] op, input logic [16:0] row,
                                            input logic [9:0] col, input logic ap,
                                            input logic bcn);
        int a;
        case (op)
            OP_ACT:  a = int'(row);
            OP_RD:   a = 5 * 16384 + int'(bcn) * 4096 + int'(ap) * 1024 + int'(col);
            OP_WR:   a = 4 * 16384 + int'(bcn) * 4096 + int'(ap) * 1024 + int'(col);
            OP_PRE:  a = 2 * 16384;
            OP_PREA: a = 2 * 16384 + 1024;
            OP_REF:  a = 16384;
            default: a = 'h1FFFF;
        endcase
        return 17'(a);
    endfunction

    function automatic logic ref_par(input logic act_n, input logic [1:0] bg,
                                     input logic [1:0] ba, input logic [16:0] addr);
        int ones = int'(act_n);
        for (int i = 0; i < 2; i++) ones += int'(bg[i]) + int'(ba[i]);
        for (int i = 0; i < 17; i++) ones += int'(addr[i]);
        return (ones % 2) == 1;
    endfunction

    // Scoreboard model: time-stamp based readiness, bank table as a plain array.
    bit          mvalid = 1'b0;
    int          edge_n, rdy_edge, cke_edge;
    bit          open_m [16];
    logic        e_cke, e_rdy, e_err, e_cs_n, e_act_n, e_par;
    logic [16:0] e_addr;
    logic [1:0]  e_bg, e_ba;
    int          dut_acc [$];

    always @(posedge clk) begin
        bit acc, bad, any;
        int idx, wt;
        if (rst) begin
            mvalid = 1'b1;
            edge_n = 0;
            cke_edge = T_INIT;
            rdy_edge = T_INIT;
            foreach (open_m[i]) open_m[i] = 1'b0;
            e_cke = 0; e_rdy = 0; e_err = 0; e_cs_n = 1; e_act_n = 1;
            e_addr = '0; e_bg = '0; e_ba = '0; e_par = 0;
        end else if (mvalid) begin
            edge_n++;
            if (cmd_vld && cmd_rdy) dut_acc.push_back(edge_n);
            acc = cmd_vld && e_rdy;
            e_err = 0; e_cs_n = 1; e_act_n = 1; e_addr = 17'h1FFFF; e_bg = '0; e_ba = '0;
            if (acc) begin
                idx = int'(cmd_bg) * 4 + int'(cmd_ba);
                any = 1'b0;
                foreach (open_m[i]) any |= open_m[i];
                bad = 1'b0;
                wt = 0;
                case (cmd_op)
                    OP_ACT:        begin bad = open_m[idx];  wt = T_RCD; end
                    OP_RD, OP_WR:  begin bad = !open_m[idx]; wt = T_CCD; end
                    OP_PRE, OP_PREA: wt = T_RP;
                    OP_REF:        begin bad = any;          wt = T_RFC; end
                    OP_RSV:        bad = 1'b1;
                    default: ;
                endcase
                if (bad) begin
                    e_err = 1;
                end else if (cmd_op != OP_DES) begin
                    e_cs_n = 0;
                    e_act_n = (cmd_op != OP_ACT);
                    e_bg = cmd_bg;
                    e_ba = cmd_ba;
                    e_addr = ca_addr(cmd_op, cmd_row, cmd_col, cmd_ap, cmd_bc_n);
                    rdy_edge = edge_n + wt - 1;
                    if (cmd_op == OP_ACT) open_m[idx] = 1'b1;
                    if ((cmd_op == OP_RD || cmd_op == OP_WR) && cmd_ap) open_m[idx] = 1'b0;
                    if (cmd_op == OP_PRE) open_m[idx] = 1'b0;
                    if (cmd_op == OP_PREA) foreach (open_m[i]) open_m[i] = 1'b0;
                end
            end
            e_cke = (edge_n >= cke_edge);
            e_rdy = (edge_n >= rdy_edge);
            e_par = ref_par(e_act_n, e_bg, e_ba, e_addr);
        end
        #1;
        if (mvalid) begin
            chk("cke", ddr4_cke, e_cke);
            chk("cmd_rdy", cmd_rdy, e_rdy);
            chk("cmd_err", cmd_err, e_err);
            chk("cs_n", ddr4_cs_n, e_cs_n);
            chk("act_n", ddr4_act_n, e_act_n);
            chk("addr", ddr4_addr, e_addr);
            chk("bg", ddr4_bg, e_bg);
            chk("ba", ddr4_ba, e_ba);
            chk("par", ddr4_par, e_par);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [16:0] row, input logic [9:0] col, input logic ap,
                        input logic bcn);
        int guard = 0;
        while (!cmd_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("rdy_before_send", cmd_rdy, 1'b1);
        cmd_vld = 1'b1; cmd_op = op; cmd_bg = bg; cmd_ba = ba;
        cmd_row = row; cmd_col = col; cmd_ap = ap; cmd_bc_n = bcn;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_op = 3'($urandom); cmd_bg = 2'($urandom); cmd_ba = 2'($urandom);
        cmd_row = 17'($urandom); cmd_col = 10'($urandom);
        cmd_ap = 1'($urandom); cmd_bc_n = 1'($urandom);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!cmd_rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_pins();
        chk("rst_cke", ddr4_cke, 1'b0);
        chk("rst_rdy", cmd_rdy, 1'b0);
        chk("rst_cs_n", ddr4_cs_n, 1'b1);
        chk("rst_act_n", ddr4_act_n, 1'b1);
        chk("rst_addr", ddr4_addr, 17'h00000);
        chk("rst_par", ddr4_par, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_pins();
        rst = 1'b0;
        count_busy(n);
        chk("init_cycles", n, 16);
        chk("init_cke", ddr4_cke, 1'b1);

        // ACT then RD to the same bank
        send(OP_ACT, 2'd1, 2'd2, 17'h00123, 10'h0, 1'b0, 1'b1);
        chk("act_act_n", ddr4_act_n, 1'b0);
        chk("act_cs_n", ddr4_cs_n, 1'b0);
        chk("act_addr", ddr4_addr, 17'h00123);
        chk("act_bg", ddr4_bg, 2'd1);
        chk("act_ba", ddr4_ba, 2'd2);
        chk("act_par", ddr4_par, 1'b0);
        count_busy(n);
        chk("trcd_busy", n, 3);
        send(OP_RD, 2'd1, 2'd2, 17'h0, 10'h010, 1'b0, 1'b1);
        chk("rd_addr", ddr4_addr, 17'h15010);
        chk("rd_act_n", ddr4_act_n, 1'b1);
        chk("rd_par", ddr4_par, 1'b1);
        chk("act_to_rd", dut_acc[dut_acc.size()-1] - dut_acc[dut_acc.size()-2], 4);
        count_busy(n);

        // RD to a closed bank
        send(OP_RD, 2'd0, 2'd0, 17'h0, 10'h055, 1'b0, 1'b1);
        chk("rdc_err", cmd_err, 1'b1);
        chk("rdc_cs_n", ddr4_cs_n, 1'b1);
        chk("rdc_addr", ddr4_addr, 17'h1FFFF);
        chk("rdc_rdy", cmd_rdy, 1'b1);
        @(negedge clk);
        chk("rdc_err_pulse", cmd_err, 1'b0);

        // REF with an open bank, then PREA and REF
        send(OP_REF, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("ref_open_err", cmd_err, 1'b1);
        send(OP_PREA, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("prea_addr", ddr4_addr, 17'h08400);
        count_busy(n);
        chk("trp_busy", n, 3);
        send(OP_REF, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("ref_addr", ddr4_addr, 17'h04000);
        chk("ref_par", ddr4_par, 1'b0);
        count_busy(n);
        chk("trfc_busy", n, 31);

        // WR with auto-precharge closes the bank
        send(OP_ACT, 2'd2, 2'd1, 17'h1ABCD, 10'h0, 1'b0, 1'b1);
        count_busy(n);
        send(OP_WR, 2'd2, 2'd1, 17'h0, 10'h3FF, 1'b1, 1'b0);
        chk("wr_addr", ddr4_addr, 17'h107FF);
        count_busy(n);
        send(OP_RD, 2'd2, 2'd1, 17'h0, 10'h001, 1'b0, 1'b1);
        chk("rd_after_ap_err", cmd_err, 1'b1);
        @(negedge clk);

        // Reserved op, DES, PRE to closed bank, ACT to open bank
        send(OP_RSV, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("rsvd_err", cmd_err, 1'b1);
        send(OP_DES, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("des_err", cmd_err, 1'b0);
        chk("des_rdy", cmd_rdy, 1'b1);
        send(OP_PRE, 2'd1, 2'd1, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("pre_closed_err", cmd_err, 1'b0);
        chk("pre_addr", ddr4_addr, 17'h08000);
        count_busy(n);
        send(OP_ACT, 2'd3, 2'd3, 17'h00001, 10'h0, 1'b0, 1'b1);
        count_busy(n);
        send(OP_ACT, 2'd3, 2'd3, 17'h00002, 10'h0, 1'b0, 1'b1);
        chk("act_open_err", cmd_err, 1'b1);
        send(OP_PRE, 2'd3, 2'd3, 17'h0, 10'h0, 1'b0, 1'b1);
        count_busy(n);

        // Reset during tRCD wait clears bank state
        send(OP_ACT, 2'd0, 2'd1, 17'h00100, 10'h0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_pins();
        rst = 1'b0;
        count_busy(n);
        chk("reinit_cycles", n, 16);
        send(OP_RD, 2'd0, 2'd1, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("bank_cleared_err", cmd_err, 1'b1);

        // Reset during tRFC wait
        send(OP_REF, 2'd0, 2'd0, 17'h0, 10'h0, 1'b0, 1'b1);
        chk("ref2_addr", ddr4_addr, 17'h04000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_pins();
        rst = 1'b0;
        count_busy(n);
        chk("reinit2_cycles", n, 16);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
